sdpram_burst_reader: RTL and testbench

Read-side burst controller placed directly downstream of `simple_dual_port_ram` port B. It accepts a burst request (start address, beat count) and drives the RAM read address one beat per cycle. It tracks the RAM's fixed read latency and returns the data as a valid/ready stream with a last-beat marker. A small credit-controlled output buffer absorbs backpressure, so no read data is ever dropped.

---
 rtl/sdpram_pkg.sv | 21 ++
 rtl/sdpram_rd_buf.sv | 77 +++++++
 rtl/sdpram_burst_reader.sv | 192 +++++++++++++++++++
 tb/tb_sdpram_burst_reader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdpram_pkg.sv
// ---------------------------------------------------------------------------
// sdpram_pkg
// Shared definitions for the simple_dual_port_ram read-side burst logic:
//   burst_state_t      : burst controller states (IDLE, ISSUE, DRAIN)
//   SDPRAM_DATA_WIDTH  : default RAM word width
//   SDPRAM_MEM_DEPTH   : default RAM depth in words
//   SDPRAM_RD_LATENCY  : default RAM read latency in cycles
// ---------------------------------------------------------------------------
package sdpram_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } burst_state_t;

   localparam int SDPRAM_DATA_WIDTH = 8;
   localparam int SDPRAM_MEM_DEPTH  = 16;
   localparam int SDPRAM_RD_LATENCY = 3;

endpackage

// File: rtl/sdpram_rd_buf.sv
// ---------------------------------------------------------------------------
// sdpram_rd_buf
// Small synchronous first-word-fall-through FIFO that holds read data returned
// by the RAM until the stream consumer takes it.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-low reset
//   push  in   write din at this edge
//   din   in   WIDTH-bit entry to store
//   pop   in   consume the head entry at this edge
//   dout  out  head entry (zero while empty)
//   count out  current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module sdpram_rd_buf
   import sdpram_pkg::*;
#(
   parameter int WIDTH = SDPRAM_DATA_WIDTH + 1,
   parameter int DEPTH = SDPRAM_RD_LATENCY + 1,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   // A pop of an empty buffer is ignored; a push into a full buffer is only
   // accepted when a pop frees a slot at the same edge.
   assign pop_ok  = pop && (count != '0);
   assign push_ok = push && ((count != FULL_CNT) || pop_ok);

   // Masking the head while empty keeps stale words off the stream after reset.
   assign dout = (count != '0) ? mem[rd_ptr] : '0;

   // Storage needs no reset; the occupancy count decides what is visible.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointer and occupancy bookkeeping; push and pop together leave count alone.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         assert (count <= FULL_CNT);
         if (push_ok) begin
            wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sdpram_burst_reader.sv
// ---------------------------------------------------------------------------
// sdpram_burst_reader
// Read-side burst controller for simple_dual_port_ram port B. Accepts a burst
// (start address, beat count), issues one RAM read per cycle while output
// buffer credit allows, tracks the fixed RAM latency and returns the words as
// a valid/ready stream with a last-beat marker.
// Build option:
//   SDPRAM_BURST_WRAP_EN  defined: addresses wrap modulo MEM_DEPTH and only a
//                         zero length is rejected. Undefined: a burst running
//                         past the end of memory is also rejected.
// Ports:
//   clk, rst              clock (rising edge), synchronous active-low reset
//   req_valid/req_ready   burst request handshake
//   req_addr, req_len     first word address, beat count (0 is illegal)
//   req_err               one-cycle pulse after a rejected request
//   ram_addrb, ram_doutb  RAM read address out, RAM read data in
//   m_data/m_valid/m_ready/m_last  output stream
//   busy                  controller is not idle
// ---------------------------------------------------------------------------
module sdpram_burst_reader
   import sdpram_pkg::*;
#(
   parameter int DATA_WIDTH = SDPRAM_DATA_WIDTH,
   parameter int MEM_DEPTH  = SDPRAM_MEM_DEPTH,
   parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
   parameter int LEN_WIDTH  = 8,
   parameter int RD_LATENCY = SDPRAM_RD_LATENCY,
   parameter int BUF_DEPTH  = RD_LATENCY + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [LEN_WIDTH-1:0]  req_len,
   output logic                  req_err,
   output logic [ADDR_WIDTH-1:0] ram_addrb,
   input  logic [DATA_WIDTH-1:0] ram_doutb,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic                  busy
);

   localparam int CNT_W = $clog2(BUF_DEPTH + 1);
   localparam int CW    = $clog2(BUF_DEPTH + RD_LATENCY + 2) + 1;
   localparam logic [CW-1:0]         CREDIT_MAX = CW'(BUF_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(MEM_DEPTH - 1);
   localparam logic [LEN_WIDTH-1:0]  LEN_ONE    = LEN_WIDTH'(1);

   burst_state_t            state;
   burst_state_t            state_next;
   logic [ADDR_WIDTH-1:0]   cur_addr;
   logic [LEN_WIDTH-1:0]    remaining;
   logic [RD_LATENCY-1:0]   sr_issued;
   logic [RD_LATENCY-1:0]   sr_last;
   logic                    req_err_q;
   logic                    req_fire;
   logic                    req_illegal;
   logic                    issue;
   logic                    issue_last;
   logic                    credit_ok;
   logic                    pop;
   logic                    push;
   logic [CW-1:0]           inflight;
   logic [CNT_W-1:0]        buf_count;
   logic [DATA_WIDTH:0]     buf_dout;

   assign req_ready = (state == IDLE) && rst;
   assign req_fire  = req_valid && req_ready;
   assign req_err   = req_err_q;
   assign ram_addrb = cur_addr;
   assign busy      = (state != IDLE);
   assign m_valid   = (buf_count != '0);
   assign pop       = m_valid && m_ready;
   assign push      = sr_issued[RD_LATENCY-1];
   assign {m_last, m_data} = buf_dout;
   assign issue_last = issue && (remaining == LEN_ONE);

`ifdef SDPRAM_BURST_WRAP_EN
   assign req_illegal = (req_len == '0);
`else
   // The end address is formed one bit wider than both operands combined so
   // the overrun test can never be fooled by a carry out.
   localparam int SUM_W = LEN_WIDTH + ADDR_WIDTH + 1;
   localparam logic [SUM_W-1:0] MEM_END = SUM_W'(MEM_DEPTH);
   logic [SUM_W-1:0] req_end;
   assign req_end     = SUM_W'(req_addr) + SUM_W'(req_len);
   assign req_illegal = (req_len == '0) || (req_end > MEM_END);
`endif

   // Reads still travelling through the RAM pipeline hold a buffer slot each,
   // so they are counted against the credit alongside the current occupancy.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         inflight = inflight + CW'(sr_issued[i]);
      end
   end

   // A slot freed by this cycle's pop can be reused immediately, which is what
   // keeps a steady stream running without bubbles.
   assign credit_ok = ((inflight + CW'(buf_count)) - CW'(pop)) < CREDIT_MAX;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and issue decision. DRAIN waits for the pipeline to empty and
   // for the final beat to leave the buffer before accepting new work.
   always_comb begin
      state_next = state;
      issue      = 1'b0;
      case (state)
         IDLE: begin
            if (req_fire && !req_illegal) begin
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (credit_ok) begin
               issue = 1'b1;
               if (remaining == LEN_ONE) begin
                  state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            if ((inflight == '0) && ((buf_count == '0) || (pop && m_last))) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Burst address/length tracking and the rejection pulse. Rejected requests
   // are consumed without touching the burst registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cur_addr  <= '0;
         remaining <= '0;
         req_err_q <= 1'b0;
      end else begin
         req_err_q <= req_fire && req_illegal;
         if (req_fire && !req_illegal) begin
            cur_addr  <= req_addr;
            remaining <= req_len;
         end else if (issue) begin
            cur_addr  <= (cur_addr == LAST_ADDR) ? '0 : cur_addr + 1'b1;
            remaining <= remaining - 1'b1;
         end
      end
   end

   // Latency pipeline mirroring the RAM: each stage records whether a read was
   // issued in that slot and whether it was the final beat of the burst.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sr_issued <= '0;
         sr_last   <= '0;
      end else begin
         sr_issued[0] <= issue;
         sr_last[0]   <= issue_last;
         for (int i = 1; i < RD_LATENCY; i++) begin
            sr_issued[i] <= sr_issued[i-1];
            sr_last[i]   <= sr_last[i-1];
         end
      end
   end

   sdpram_rd_buf #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (BUF_DEPTH),
      .CNT_W (CNT_W)
   ) u_rd_buf (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   ({sr_last[RD_LATENCY-1], ram_doutb}),
      .pop   (pop),
      .dout  (buf_dout),
      .count (buf_count)
   );

endmodule

// File: tb/tb_sdpram_burst_reader.sv
// ---------------------------------------------------------------------------
// tb_sdpram_burst_reader
// Self-checking bench for sdpram_burst_reader with a behavioural RAM
// (mem[i] = i + 0x10, three-cycle read latency). Expected beats are queued
// when a request is issued and a monitor compares every stream handshake.
// Honours SDPRAM_BURST_WRAP_EN for the expected legality of requests.
// ---------------------------------------------------------------------------
module tb_sdpram_burst_reader;

   localparam int DW  = 8;
   localparam int MD  = 16;
   localparam int AW  = 4;
   localparam int LW  = 8;
   localparam int LAT = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW-1:0] req_addr = '0;
   logic [LW-1:0] req_len = '0;
   logic          req_err;
   logic [AW-1:0] ram_addrb;
   logic [DW-1:0] ram_doutb;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic          m_last;
   logic          busy;

   int tests = 0;
   int fails = 0;
   int readyMode = 0;
   int patIdx = 0;

   logic [DW:0]   expq [$];
   logic [DW-1:0] mem [MD];
   logic [DW-1:0] ramPipe [LAT];

   logic          prevStall = 1'b0;
   logic [DW-1:0] prevData = '0;
   logic          prevLast = 1'b0;

   always #5 clk = ~clk;

   sdpram_burst_reader #(
      .DATA_WIDTH (DW),
      .MEM_DEPTH  (MD),
      .ADDR_WIDTH (AW),
      .LEN_WIDTH  (LW),
      .RD_LATENCY (LAT),
      .BUF_DEPTH  (LAT + 1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .req_err   (req_err),
      .ram_addrb (ram_addrb),
      .ram_doutb (ram_doutb),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_last    (m_last),
      .busy      (busy)
   );

   // Behavioural RAM: contents fixed, read data appears LAT cycles after the address.
   initial begin
      for (int i = 0; i < MD; i++) mem[i] = DW'(i + 'h10);
      for (int i = 0; i < LAT; i++) ramPipe[i] = '0;
   end

   always @(posedge clk) begin
      ramPipe[0] <= mem[ram_addrb];
      for (int i = 1; i < LAT; i++) ramPipe[i] <= ramPipe[i-1];
   end

   assign ram_doutb = ramPipe[LAT-1];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic bit isLegal(input int addr, input int len);
`ifdef SDPRAM_BURST_WRAP_EN
      return (len != 0);
`else
      return (len != 0) && (addr + len <= MD);
`endif
   endfunction

   // Consumer ready pattern: 0 always ready, 1 random, 2 repeating 1,0,0.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (readyMode)
            0: m_ready = 1'b1;
            1: m_ready = 1'($urandom_range(0, 1));
            default: begin
               m_ready = (patIdx % 3 == 0);
               patIdx++;
            end
         endcase
      end
   end

   // Stream monitor: every accepted beat must match the head of the expected
   // queue, and a stalled beat must not change until it is taken.
   always @(negedge clk) begin
      if (rst) begin
         if (prevStall) begin
            checkOutput("stall_valid", 32'(m_valid), 32'd1);
            checkOutput("stall_data", 32'(m_data), 32'(prevData));
            checkOutput("stall_last", 32'(m_last), 32'(prevLast));
         end
         if (m_valid && m_ready) begin
            if (expq.size() == 0) begin
               tests++;
               fails++;
               $display("[TB] FAIL unexpected_beat: got data 0x%0h last %0b, expected no beat at %0t", m_data, m_last, $time);
            end else begin
               checkOutput("beat", 32'({m_last, m_data}), 32'(expq.pop_front()));
            end
         end
         prevStall = m_valid && !m_ready;
         prevData  = m_data;
         prevLast  = m_last;
      end else begin
         prevStall = 1'b0;
      end
   end

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      checkOutput({tag, "_req_err"}, 32'(req_err), 32'd0);
      checkOutput({tag, "_ram_addrb"}, 32'(ram_addrb), 32'd0);
      checkOutput({tag, "_m_valid"}, 32'(m_valid), 32'd0);
      checkOutput({tag, "_m_last"}, 32'(m_last), 32'd0);
      checkOutput({tag, "_m_data"}, 32'(m_data), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   // Present one request, wait for its handshake edge and queue the expected beats.
   task automatic applyRequest(input int addr, input int len);
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_addr  = AW'(addr);
      req_len   = LW'(len);
      @(negedge clk);
      checkOutput("req_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      if (isLegal(addr, len)) begin
         for (int i = 0; i < len; i++) begin
            expq.push_back({1'(i == len - 1), DW'(((addr + i) % MD) + 'h10)});
         end
      end
   endtask

   // Full request: handshake, then follow the burst to completion with a cycle budget.
   task automatic applyStimulus(input int addr, input int len, output int firstK, output int lastK);
      bit legal;
      bit done;
      bit sawBusy;
      bit sawValid;
      int errCount;
      legal    = isLegal(addr, len);
      done     = 1'b0;
      sawBusy  = 1'b0;
      sawValid = 1'b0;
      errCount = 0;
      firstK   = -1;
      lastK    = -1;
      applyRequest(addr, len);
      for (int k = 0; k < 400 && !done; k++) begin
         @(negedge clk);
         if (k == 0) begin
            checkOutput("req_err_pulse", 32'(req_err), 32'(!legal));
            checkOutput("busy_after_req", 32'(busy), 32'(legal));
         end
         if (req_err) errCount++;
         if (busy) sawBusy = 1'b1;
         if (m_valid) sawValid = 1'b1;
         if (m_valid && firstK < 0) firstK = k;
         if (m_valid && m_ready) lastK = k;
         if (legal) done = (k > 0) && !busy && (expq.size() == 0);
         else done = (k >= 4);
      end
      checkOutput("burst_done", 32'(done), 32'd1);
      checkOutput("req_err_count", 32'(errCount), legal ? 32'd0 : 32'd1);
      if (!legal) begin
         checkOutput("illegal_busy", 32'(sawBusy), 32'd0);
         checkOutput("illegal_valid", 32'(sawValid), 32'd0);
      end else begin
         checkOutput("first_valid_cycle", 32'(firstK), 32'd4);
      end
   endtask

   // Global time limit so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, tests run %0d", tests);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int f;
      int l;
      int addr;
      int len;
      bit mvSeen;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkResetValues("por");
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      checkOutput("ready_after_reset", 32'(req_ready), 32'd1);

      $display("[TB] single burst addr=2 len=4");
      readyMode = 0;
      applyStimulus(2, 4, f, l);
      checkOutput("single_last_gap", 32'(l - f), 32'd3);

      $display("[TB] backpressure addr=0 len=8");
      readyMode = 2;
      patIdx = 0;
      applyStimulus(0, 8, f, l);

      $display("[TB] boundary addr=14 len=4");
      readyMode = 0;
      applyStimulus(14, 4, f, l);
`ifdef SDPRAM_BURST_WRAP_EN
      checkOutput("wrap_last_gap", 32'(l - f), 32'd3);
`endif
      applyStimulus(12, 4, f, l);

      $display("[TB] illegal length then legal burst");
      applyStimulus(3, 0, f, l);
      applyStimulus(7, 3, f, l);

      $display("[TB] reset mid-burst");
      readyMode = 0;
      applyRequest(0, 8);
      mvSeen = 1'b0;
      for (int k = 0; k < 20 && !mvSeen; k++) begin
         @(negedge clk);
         mvSeen = m_valid;
      end
      checkOutput("reset_burst_started", 32'(mvSeen), 32'd1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      expq.delete();
      @(posedge clk);
      @(negedge clk);
      checkResetValues("mid");
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      checkOutput("ready_after_release", 32'(req_ready), 32'd1);
      applyStimulus(5, 2, f, l);

      $display("[TB] randomized bursts");
      for (int n = 0; n < 25; n++) begin
         readyMode = $urandom_range(0, 2);
         addr = $urandom_range(0, MD - 1);
         len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 18);
         applyStimulus(addr, len, f, l);
         if (readyMode == 0 && isLegal(addr, len)) begin
            checkOutput("rand_throughput", 32'(l - f), 32'(len - 1));
         end
      end

      repeat (5) @(negedge clk);
      checkOutput("scoreboard_empty", 32'(expq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
